csa_resolver: RTL

- Pipelined carry-propagate stage for the multiplier datapath. It consumes the redundant {carry, sum} pair produced by the carry-save compression tree and resolves it into a single binary value.
- The addition is split into CHUNK_WIDTH slices, one slice per pipeline stage, with the carry registered between stages. This keeps the long ripple path off the critical path.
- The block sits between the CSA tree and the multiplier result register, with valid/ready flow control on both sides.

---
 rtl/csa_resolver.sv | 105 ++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Pipelined carry-propagate adder that resolves a redundant {carry, sum} pair
// one CHUNK_WIDTH slice per stage, with the inter-chunk carry registered between stages.
module csa_resolver #(
  parameter  int DATA_WIDTH  = 64,
  parameter  int CHUNK_WIDTH = 16,
  localparam int NUM_STAGES  = DATA_WIDTH / CHUNK_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] redundant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_sum,
  output logic                    out_carry
);

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("csa_resolver: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  logic adv;

  // *_in[k] feed stage k; *_q[k] are the registers of stage k.
  logic                  v_in   [NUM_STAGES];
  logic                  cy_in  [NUM_STAGES];
  logic [DATA_WIDTH-1:0] res_in [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_in   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] c_in   [NUM_STAGES];
  logic                  v_q    [NUM_STAGES];
  logic                  cy_q   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] res_q  [NUM_STAGES];

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & ~rst;
  assign out_valid = v_q[NUM_STAGES-1];
  assign out_sum   = res_q[NUM_STAGES-1];
  assign out_carry = cy_q[NUM_STAGES-1];

  assign v_in[0]   = in_valid & in_ready;
  assign cy_in[0]  = 1'b0;
  assign res_in[0] = '0;
  assign s_in[0]   = redundant[DATA_WIDTH-1:0];
  assign c_in[0]   = redundant[2*DATA_WIDTH-1:DATA_WIDTH];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [CHUNK_WIDTH:0]  chunk_add;
    logic [DATA_WIDTH-1:0] res_next;
    logic                  v_r;
    logic                  cy_r;
    logic [DATA_WIDTH-1:0] r_r;

    // Operands arrive shifted so the chunk to add always sits in the low bits.
    assign chunk_add = {1'b0, s_in[k][CHUNK_WIDTH-1:0]}
                     + {1'b0, c_in[k][CHUNK_WIDTH-1:0]}
                     + {{CHUNK_WIDTH{1'b0}}, cy_in[k]};

    always_comb begin
      res_next = res_in[k];
      res_next[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_add[CHUNK_WIDTH-1:0];
    end

    // Data registers load only with a valid slot so the output holds across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r  <= 1'b0;
        cy_r <= 1'b0;
        r_r  <= '0;
      end else if (adv) begin
        v_r <= v_in[k];
        if (v_in[k]) begin
          cy_r <= chunk_add[CHUNK_WIDTH];
          r_r  <= res_next;
        end
      end
    end

    assign v_q[k]   = v_r;
    assign cy_q[k]  = cy_r;
    assign res_q[k] = r_r;

    if (k < NUM_STAGES - 1) begin : g_skew
      logic [DATA_WIDTH-1:0] s_r;
      logic [DATA_WIDTH-1:0] c_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_r <= '0;
          c_r <= '0;
        end else if (adv && v_in[k]) begin
          s_r <= s_in[k] >> CHUNK_WIDTH;
          c_r <= c_in[k] >> CHUNK_WIDTH;
        end
      end

      assign v_in[k+1]   = v_r;
      assign cy_in[k+1]  = cy_r;
      assign res_in[k+1] = r_r;
      assign s_in[k+1]   = s_r;
      assign c_in[k+1]   = c_r;
    end
  end

endmodule
